// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game datapath: FSM state encoding,
// bus widths and the four one-hot colour codes.
package genius_pkg;

  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [COLOR_W-1:0] VERDE    = 4'b0001;
  localparam logic [COLOR_W-1:0] VERMELHO = 4'b0010;
  localparam logic [COLOR_W-1:0] AZUL     = 4'b0100;
  localparam logic [COLOR_W-1:0] AMARELO  = 4'b1000;

endpackage

// File: rtl/seq_timer.sv
// Cycle counter with synchronous clear; tc flags the cycle in which the count
// equals the limit, so an interval of N cycles uses limit N-1.
module seq_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               tc
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/seq_player.sv
// Genius playback stage: walks the sequence ROM from address 0 to the sampled
// level, showing each colour for ON_CYCLES followed by an OFF_CYCLES blank gap.
module seq_player
  import genius_pkg::*;
#(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int TIMER_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  level,
  output logic [ADDR_W-1:0]  address,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] leds,
  output logic               busy,
  output logic               done
);

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  last_idx;
  logic               accept;
  logic               last_step;
  logic               timer_clear;
  logic               timer_enable;
  logic               timer_tc;
  logic [TIMER_W-1:0] timer_limit;

  assign accept    = (state == IDLE) && start;
  assign last_step = (address == last_idx);

  // One timer serves both intervals; the limit follows the current state.
  assign timer_enable = (state == ON) || (state == OFF);
  assign timer_clear  = accept || (timer_enable && timer_tc);
  assign timer_limit  = (state == OFF) ? OFF_LAST : ON_LAST;

  seq_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit),
    .tc     (timer_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      address  <= '0;
      last_idx <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_idx <= level;
        address  <= '0;
      end else if ((state == OFF) && timer_tc && !last_step) begin
        address <= address + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ON;
      ON:      if (timer_tc) state_next = OFF;
      OFF:     if (timer_tc) state_next = last_step ? DONE : ON;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    leds = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ON: begin
        leds = rom_data;
        busy = 1'b1;
      end
      OFF:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
